// File: rtl/npu_instr_sequencer.sv
// npu_instr_sequencer: paces one convolution job into the scheduler's instr stream (A load, B load, per-sub-image C/wait/write-back).
// Optional `NPU_SEQ_WEIGHT_KEEP_EN adds cfg_keep_a, which skips the A load phase.
module npu_instr_sequencer #(
  parameter int N = 10,
  parameter int K_SIZE = 3,
  parameter int SUB_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cfg_relu,
  input  logic             cfg_broadcast,
  input  logic             cfg_reuse,
  input  logic [SUB_W-1:0] cfg_num_sub,
`ifdef NPU_SEQ_WEIGHT_KEEP_EN
  input  logic             cfg_keep_a,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       instr,
  output logic             busy,
  output logic             done,
  output logic [SUB_W-1:0] sub_idx
);
  localparam int A_DEPTH = N * K_SIZE;
  localparam int B_DEPTH = N * K_SIZE;
  localparam int C_DEPTH = K_SIZE;
  localparam int MAX_D = A_DEPTH > K_SIZE * K_SIZE ? A_DEPTH : K_SIZE * K_SIZE;
  localparam int BW = MAX_D > 1 ? $clog2(MAX_D) : 1;
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, LOAD_C, WAIT, WB, DONE} state_t;
  state_t state, state_d;
  logic relu_q, bc_q, reuse_q, accept, end_beat, last_sub, skip_a;
  logic [SUB_W-1:0] num_q;
  logic [BW-1:0] beat, last;
  logic [1:0] mode;
  logic [7:0] cfg_word, instr_d;
`ifdef NPU_SEQ_WEIGHT_KEEP_EN
  assign skip_a = cfg_keep_a;
`else
  assign skip_a = 1'b0;
`endif
  // One beat counter serves every phase; it restarts at each phase change.
  always_comb begin
    last = state == LOAD_A ? BW'(A_DEPTH - 1) : state == LOAD_B ? BW'(B_DEPTH - 1) :
           state == LOAD_C ? BW'(C_DEPTH - 1) : reuse_q ? BW'(K_SIZE * K_SIZE - 1) : BW'(K_SIZE - 1);
    accept = in_valid && in_ready;
    end_beat = beat == last && (accept || state == WAIT);
    last_sub = sub_idx == num_q - 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = start ? (skip_a ? LOAD_B : LOAD_A) : IDLE;
      LOAD_A:  state_d = end_beat ? LOAD_B : LOAD_A;
      LOAD_B:  state_d = end_beat ? (num_q != '0 ? LOAD_C : DONE) : LOAD_B;
      LOAD_C:  state_d = end_beat ? WAIT : LOAD_C;
      WAIT:    state_d = end_beat ? WB : WAIT;
      WB:      state_d = last_sub ? DONE : LOAD_C;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    in_ready = state == LOAD_A || state == LOAD_B || state == LOAD_C;
    busy = state != IDLE;
    done = state == DONE;
    mode = state == LOAD_A ? 2'd1 : state == LOAD_B ? 2'd2 : 2'd3;
    cfg_word = {1'b0, reuse_q, 2'b11, relu_q, bc_q, 2'b00};
    instr_d = state == IDLE || state == DONE ? 8'h30 :
              state == WB ? {1'b0, reuse_q, 2'(sub_idx % SUB_W'(3)), relu_q, bc_q, 2'b00} :
              accept ? cfg_word | {6'b0, mode} : cfg_word;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      instr <= 8'h30;
      beat <= '0;
      sub_idx <= '0;
      relu_q <= 1'b0;
      bc_q <= 1'b0;
      reuse_q <= 1'b0;
      num_q <= '0;
    end else begin
      instr <= instr_d;
      beat <= state == IDLE || end_beat ? '0 : accept || state == WAIT ? beat + 1'b1 : beat;
      if (state == IDLE && start) begin
        relu_q <= cfg_relu;
        bc_q <= cfg_broadcast;
        reuse_q <= cfg_reuse;
        num_q <= cfg_num_sub;
        sub_idx <= '0;
      end else if (state == WB && !last_sub) sub_idx <= sub_idx + 1'b1;
    end
endmodule

// File: tb/tb_npu_instr_sequencer.sv
// tb_npu_instr_sequencer: job table + random valid gaps checked against a phase-list reference model.
module tb_npu_instr_sequencer;
  logic clk = 0, rst_n = 0, start = 0, cfg_relu = 0, cfg_broadcast = 0, cfg_reuse = 0, in_valid = 0, keep_a = 0;
  logic [7:0] cfg_num_sub = 0;
  logic in_ready, busy, done;
  logic [7:0] instr, sub_idx;
  int checks = 0, failures = 0;
  logic [7:0] w [0:1023];
  typedef struct {int kind; int cnt; int sub;} ph_t;
  typedef struct {bit relu; bit bc; bit reuse; bit keep; bit rnd; bit noise; int n; int exp_done; int exp_words;} vec_t;
  ph_t q[$];
  always #5 clk = ~clk;
  npu_instr_sequencer dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .cfg_relu(cfg_relu),
    .cfg_broadcast(cfg_broadcast),
    .cfg_reuse(cfg_reuse),
    .cfg_num_sub(cfg_num_sub),
`ifdef NPU_SEQ_WEIGHT_KEEP_EN
    .cfg_keep_a(keep_a),
`endif
    .in_valid(in_valid),
    .in_ready(in_ready),
    .instr(instr),
    .busy(busy),
    .done(done),
    .sub_idx(sub_idx)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Job as a list of phases: each entry is emitted for cnt cycles (load phases count accepts only).
  task automatic run_job(input vec_t v, output int done_cyc, output int words);
    int wl, esub, k;
    bit acc, fin;
    logic [7:0] ex, cfgb;
    wl = v.reuse ? 9 : 3;
    q = {};
    if (!v.keep) q.push_back('{1, 30, 0});
    q.push_back('{2, 30, 0});
    for (int s = 0; s < v.n; s++) begin
      q.push_back('{3, 3, s});
      q.push_back('{4, wl, s});
      q.push_back('{5, 1, s});
    end
    q.push_back('{6, 1, v.n > 0 ? v.n - 1 : 0});
    cfgb = {1'b0, v.reuse, 2'b11, v.relu, v.bc, 2'b00};
    @(negedge clk);
    cfg_relu = v.relu;
    cfg_broadcast = v.bc;
    cfg_reuse = v.reuse;
    cfg_num_sub = 8'(v.n);
    keep_a = v.keep;
    start = 1;
    in_valid = 1;
    ex = 8'h30;
    esub = 0;
    done_cyc = -1;
    words = 0;
    fin = 0;
    for (int c = 1; c <= 1000 && !fin; c++) begin
      @(negedge clk);
      if (q.size() != 0) esub = q[0].sub;
      w[c] = instr;
      chk("instr", instr, ex);
      chk("in_ready", in_ready, q.size() != 0 && q[0].kind <= 3);
      chk("busy", busy, q.size() != 0);
      chk("done", done, q.size() != 0 && q[0].kind == 6);
      chk("sub_idx", sub_idx, esub);
      if (done) done_cyc = c;
      if (instr[1:0] != 2'd0) words++;
      if (q.size() == 0) fin = 1;
      else begin
        start = v.noise && $urandom_range(0, 7) == 0;
        if (v.noise) begin
          cfg_relu = 1'($urandom);
          cfg_broadcast = 1'($urandom);
          cfg_reuse = 1'($urandom);
          cfg_num_sub = 8'($urandom);
          keep_a = 1'($urandom);
        end
        in_valid = v.rnd ? $urandom_range(0, 2) != 0 : 1'b1;
        k = q[0].kind;
        acc = in_valid && k <= 3;
        ex = k <= 3 ? (acc ? cfgb | 8'(k) : cfgb) : k == 4 ? cfgb :
             k == 5 ? {1'b0, v.reuse, 2'(q[0].sub % 3), v.relu, v.bc, 2'b00} : 8'h30;
        if (k > 3 || acc) q[0].cnt = q[0].cnt - 1;
        if (q[0].cnt == 0) void'(q.pop_front());
      end
    end
    if (!fin) chk("job_timeout", 0, 1);
    start = 0;
    in_valid = 0;
  endtask
  initial begin
    vec_t tbl[$];
    int dc, wd;
    tbl.push_back('{1, 0, 0, 0, 0, 0, 2, 75, 66});
    tbl.push_back('{0, 1, 1, 0, 0, 0, 1, 74, 63});
    tbl.push_back('{1, 1, 0, 0, 0, 1, 0, 61, 60});
    tbl.push_back('{0, 0, 1, 0, 1, 1, 3, -1, 69});
    tbl.push_back('{1, 0, 0, 0, 1, 0, 2, -1, 66});
    tbl.push_back('{1, 1, 1, 0, 0, 0, 4, 113, 72});
`ifdef NPU_SEQ_WEIGHT_KEEP_EN
    tbl.push_back('{1, 0, 0, 1, 0, 0, 2, 45, 36});
`endif
    repeat (3) @(negedge clk);
    chk("rst_instr", instr, 8'h30);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_sub_idx", sub_idx, 0);
    rst_n = 1;
    for (int i = 0; i < tbl.size(); i++) begin
      run_job(tbl[i], dc, wd);
      if (tbl[i].exp_done >= 0) chk($sformatf("row%0d_done_cycle", i), dc, tbl[i].exp_done);
      chk($sformatf("row%0d_mode_words", i), wd, tbl[i].exp_words);
      if (i == 0) begin
        chk("j0_first_a", w[2], 8'h39);
        chk("j0_first_b", w[32], 8'h3A);
        chk("j0_first_c", w[62], 8'h3B);
        chk("j0_wait", w[65], 8'h38);
        chk("j0_wb0", w[68], 8'h08);
        chk("j0_wb1", w[75], 8'h18);
        chk("j0_after_done", w[76], 8'h30);
      end
      if (i == 1) begin
        chk("j1_load_c", w[62], 8'h77);
        chk("j1_wait_first", w[65], 8'h74);
        chk("j1_wait_last", w[73], 8'h74);
        chk("j1_wb", w[74], 8'h44);
      end
    end
    // Reset in the middle of a job returns to idle without a done pulse.
    @(negedge clk);
    cfg_relu = 1;
    cfg_num_sub = 2;
    start = 1;
    in_valid = 1;
    @(negedge clk);
    start = 0;
    repeat (40) @(negedge clk);
    chk("mid_busy_before", busy, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_instr", instr, 8'h30);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_sub_idx", sub_idx, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_done", done, 0);
    end
    in_valid = 0;
    run_job(tbl[0], dc, wd);
    chk("recover_done_cycle", dc, 75);
    chk("recover_mode_words", wd, 66);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
